// File: rtl/mult_div_sequencer.sv
// Iterative signed multiply/divide unit with its own sequencing FSM.
// Shift-add multiply and restoring divide, one bit per cycle, on unsigned
// magnitudes; a single FIX cycle applies the sign correction. Results land
// in hi/lo and are held until the next successful completion or reset.
module mult_div_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start_mult,
    input  logic             start_div,
    input  logic [WIDTH-1:0] rs_value,
    input  logic [WIDTH-1:0] rt_value,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_MULT = 3'd1;
    localparam logic [2:0] S_DIV  = 3'd2;
    localparam logic [2:0] S_FIX  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    // Two's-complement negate of a WIDTH-bit value.
    function automatic logic [WIDTH-1:0] negate_w(input logic [WIDTH-1:0] v);
        negate_w = ~v + WIDTH'(1);
    endfunction

    // Unsigned magnitude; the most negative value maps to 2^(WIDTH-1) exactly.
    function automatic logic [WIDTH-1:0] abs_w(input logic [WIDTH-1:0] v);
        abs_w = v[WIDTH-1] ? negate_w(v) : v;
    endfunction

    logic [2:0]         state_r;
    logic [CNT_W-1:0]   count_r;
    logic [2*WIDTH-1:0] acc_r;      // mult: product:multiplier, div: remainder:quotient
    logic [WIDTH-1:0]   operand_r;  // mult: |multiplicand|, div: |divisor|
    logic               is_div_r;
    logic               neg_rs_r;
    logic               neg_rt_r;
    logic               busy_r;
    logic               done_r;
    logic               div_zero_r;
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;

    logic [WIDTH:0]     mul_sum_s;
    logic [2*WIDTH-1:0] mul_next_s;
    logic [WIDTH:0]     div_shift_s;
    logic [WIDTH+1:0]   div_diff_s;
    logic [2*WIDTH-1:0] div_next_s;
    logic [2*WIDTH-1:0] prod_neg_s;
    logic [WIDTH-1:0]   fix_hi_s;
    logic [WIDTH-1:0]   fix_lo_s;

    // Datapath for one multiply step, one divide step, and the sign fix.
    always_comb begin
        mul_sum_s   = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + {1'b0, operand_r};
        if (acc_r[0]) begin
            mul_next_s = {mul_sum_s, acc_r[WIDTH-1:1]};
        end else begin
            mul_next_s = {1'b0, acc_r[2*WIDTH-1:1]};
        end

        div_shift_s = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]};
        div_diff_s  = {1'b0, div_shift_s} - {2'b00, operand_r};
        if (!div_diff_s[WIDTH+1]) begin
            div_next_s = {div_diff_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
        end else begin
            div_next_s = {div_shift_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
        end

        prod_neg_s = ~acc_r + (2*WIDTH)'(1);
        if (is_div_r) begin
            // Remainder follows the dividend; quotient truncates toward zero.
            fix_hi_s = neg_rs_r ? negate_w(acc_r[2*WIDTH-1:WIDTH]) : acc_r[2*WIDTH-1:WIDTH];
            fix_lo_s = (neg_rs_r ^ neg_rt_r) ? negate_w(acc_r[WIDTH-1:0]) : acc_r[WIDTH-1:0];
        end else if (neg_rs_r ^ neg_rt_r) begin
            fix_hi_s = prod_neg_s[2*WIDTH-1:WIDTH];
            fix_lo_s = prod_neg_s[WIDTH-1:0];
        end else begin
            fix_hi_s = acc_r[2*WIDTH-1:WIDTH];
            fix_lo_s = acc_r[WIDTH-1:0];
        end
    end

    // Sequencing FSM, work registers and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r    <= S_IDLE;
            count_r    <= '0;
            acc_r      <= '0;
            operand_r  <= '0;
            is_div_r   <= 1'b0;
            neg_rs_r   <= 1'b0;
            neg_rt_r   <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            div_zero_r <= 1'b0;
            hi_r       <= '0;
            lo_r       <= '0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    done_r <= 1'b0;
                    if (start_mult || start_div) begin
                        // Multiply wins when both requests arrive together.
                        div_zero_r <= 1'b0;
                        count_r    <= '0;
                        is_div_r   <= !start_mult;
                        neg_rs_r   <= rs_value[WIDTH-1];
                        neg_rt_r   <= rt_value[WIDTH-1];
                        if (start_mult) begin
                            state_r   <= S_MULT;
                            busy_r    <= 1'b1;
                            acc_r     <= {{WIDTH{1'b0}}, abs_w(rt_value)};
                            operand_r <= abs_w(rs_value);
                        end else if (rt_value == '0) begin
                            // Divide by zero completes immediately; hi/lo untouched.
                            state_r    <= S_DONE;
                            busy_r     <= 1'b0;
                            done_r     <= 1'b1;
                            div_zero_r <= 1'b1;
                        end else begin
                            state_r   <= S_DIV;
                            busy_r    <= 1'b1;
                            acc_r     <= {{WIDTH{1'b0}}, abs_w(rs_value)};
                            operand_r <= abs_w(rt_value);
                        end
                    end else begin
                        state_r <= S_IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                S_MULT: begin
                    acc_r   <= mul_next_s;
                    count_r <= count_r + CNT_W'(1);
                    if (count_r == CNT_W'(WIDTH - 1)) begin
                        state_r <= S_FIX;
                    end else begin
                        state_r <= S_MULT;
                    end
                end
                S_DIV: begin
                    acc_r   <= div_next_s;
                    count_r <= count_r + CNT_W'(1);
                    if (count_r == CNT_W'(WIDTH - 1)) begin
                        state_r <= S_FIX;
                    end else begin
                        state_r <= S_DIV;
                    end
                end
                S_FIX: begin
                    hi_r    <= fix_hi_s;
                    lo_r    <= fix_lo_s;
                    state_r <= S_DONE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b1;
                end
                S_DONE: begin
                    // Starts seen in this cycle are deliberately dropped.
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= S_IDLE;
                end
                default: begin
                    state_r <= S_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign div_zero = div_zero_r;
    assign hi       = hi_r;
    assign lo       = lo_r;

endmodule

// File: tb/tb_mult_div_sequencer.sv
// Directed self-checking bench for mult_div_sequencer (WIDTH = 32).
module tb_mult_div_sequencer;

    logic        clock;
    logic        reset;
    logic        start_mult;
    logic        start_div;
    logic [31:0] rs_value;
    logic [31:0] rt_value;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

    mult_div_sequencer #(.WIDTH(32)) dut (
        .clock      (clock),
        .reset      (reset),
        .start_mult (start_mult),
        .start_div  (start_div),
        .rs_value   (rs_value),
        .rt_value   (rt_value),
        .busy       (busy),
        .done       (done),
        .div_zero   (div_zero),
        .hi         (hi),
        .lo         (lo)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one request, measure latency/busy span, then check results.
    // inject pulses a conflicting start mid-operation; it must be ignored.
    task automatic run_op(input string tag, input logic m, input logic d,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input logic exp_dz, input int exp_lat, input logic inject);
        int lat;
        int busy_cnt;
        bit seen;
        @(negedge clock);
        start_mult = m;
        start_div  = d;
        rs_value   = a;
        rt_value   = b;
        @(posedge clock);
        #1;
        start_mult = 1'b0;
        start_div  = 1'b0;
        rs_value   = 32'hDEAD_BEEF;
        rt_value   = 32'h0000_0000;
        lat      = 1;
        busy_cnt = 0;
        seen     = 1'b0;
        while (!seen && lat < 100) begin
            if (done) begin
                seen = 1'b1;
            end else begin
                if (busy) busy_cnt++;
                start_div = inject && (lat == 5);
                @(posedge clock);
                #1;
                start_div = 1'b0;
                lat++;
            end
        end
        check({tag, "_done_seen"}, 64'(seen), 64'd1);
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(exp_lat - 1));
        check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
        check({tag, "_hi"}, 64'(hi), 64'(exp_hi));
        check({tag, "_lo"}, 64'(lo), 64'(exp_lo));
        check({tag, "_div_zero"}, 64'(div_zero), 64'(exp_dz));
        // A start during the done cycle is ignored; done is a single pulse.
        start_mult = 1'b1;
        rs_value   = 32'd9;
        rt_value   = 32'd9;
        @(posedge clock);
        #1;
        start_mult = 1'b0;
        check({tag, "_done_pulse"}, 64'(done), 64'd0);
        check({tag, "_done_start_ignored"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int cyc;
        bit got_done;
        reset      = 1'b0;
        start_mult = 1'b0;
        start_div  = 1'b0;
        rs_value   = 32'd0;
        rt_value   = 32'd0;
        repeat (3) @(posedge clock);
        #1;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_dz", 64'(div_zero), 64'd0);
        check("reset_hi", 64'(hi), 64'd0);
        check("reset_lo", 64'(lo), 64'd0);
        @(negedge clock);
        reset = 1'b1;

        run_op("mul_7_m3", 1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 34, 1'b1);
        run_op("mul_min_min", 1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 34, 1'b0);
        run_op("mul_m5_m6", 1'b1, 1'b0, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 32'h0000_0000, 32'd30, 1'b0, 34, 1'b0);
        run_op("div_m7_2", 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 34, 1'b0);
        run_op("div_7_m2", 1'b0, 1'b1, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, 34, 1'b0);
        run_op("div_451_20", 1'b0, 1'b1, 32'h0000_0451, 32'h0000_0020, 32'h0000_0011, 32'h0000_0022, 1'b0, 34, 1'b0);
        run_op("div_by_zero", 1'b0, 1'b1, 32'd5, 32'd0, 32'h0000_0011, 32'h0000_0022, 1'b1, 1, 1'b0);
        run_op("div_min_m1", 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 34, 1'b0);
        run_op("both_starts", 1'b1, 1'b1, 32'd6, 32'd5, 32'h0000_0000, 32'd30, 1'b0, 34, 1'b0);

        // Reset during iteration 10 of a multiply abandons it silently.
        @(negedge clock);
        start_mult = 1'b1;
        rs_value   = 32'h1234_5678;
        rt_value   = 32'h0000_0FFF;
        @(posedge clock);
        #1;
        start_mult = 1'b0;
        repeat (10) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_hi", 64'(hi), 64'd0);
        check("midrst_lo", 64'(lo), 64'd0);
        @(negedge clock);
        reset = 1'b1;
        got_done = 1'b0;
        for (cyc = 0; cyc < 40; cyc++) begin
            @(posedge clock);
            #1;
            if (done || busy) got_done = 1'b1;
        end
        check("midrst_no_done", 64'(got_done), 64'd0);

        run_op("mul_3_4", 1'b1, 1'b0, 32'd3, 32'd4, 32'h0000_0000, 32'd12, 1'b0, 34, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
